// File: rtl/bram_pkg.sv
// Shared types and constants for the sprite/frame store and the OLED pixel fetcher.
package bram_pkg;

  localparam int unsigned OledAddrW = 13;
  localparam int unsigned OledDataW = 16;

  typedef enum logic {StIdle, StClear} clear_state_e;

  function automatic int unsigned be_width(int unsigned data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/bram_clear_seq.sv
// Clear engine: sweeps every implemented word once with a latched fill value.
module bram_clear_seq import bram_pkg::*; #(
  parameter int unsigned ADDR_W = OledAddrW,
  parameter int unsigned DATA_W = OledDataW,
  parameter int unsigned DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_req_i,
  input  logic [DATA_W-1:0] clear_value_i,
  output logic              clr_we_o,
  output logic [ADDR_W-1:0] clr_addr_o,
  output logic [DATA_W-1:0] clr_data_o,
  output logic              busy_o,
  output logic              clear_done_o
);

  // One extra counter bit so a full 2**ADDR_W sweep ends without wrapping.
  localparam int unsigned       CntW    = ADDR_W + 1;
  localparam logic [CntW-1:0]   LastCnt = CntW'(DEPTH - 1);

  clear_state_e      state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] val_q, val_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    val_d   = val_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (clear_req_i) begin
          val_d   = clear_value_i;
          cnt_d   = '0;
          state_d = StClear;
          busy_d  = 1'b1;
        end
      end
      StClear: begin
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          state_d = StIdle;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      val_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      val_q   <= val_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // busy_q is high exactly while the FSM is in StClear, so it doubles as the write strobe.
  assign clr_we_o     = busy_q;
  assign clr_addr_o   = cnt_q[ADDR_W-1:0];
  assign clr_data_o   = val_q;
  assign busy_o       = busy_q;
  assign clear_done_o = done_q;

endmodule

// File: rtl/bram_sprite_store.sv
// Dual-port sprite/frame memory with byte-enabled writes and a hardware clear engine.
module bram_sprite_store import bram_pkg::*; #(
  parameter int unsigned ADDR_W    = OledAddrW,
  parameter int unsigned DATA_W    = OledDataW,
  parameter int unsigned DEPTH     = 2**ADDR_W,
  parameter              INIT_FILE = "sprite.txt"
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic [ADDR_W-1:0]             wr_addr,
  input  logic [DATA_W-1:0]             wr_data,
  input  logic [be_width(DATA_W)-1:0]   wr_be,
  output logic                          wr_rejected,
  input  logic                          rd_en,
  input  logic [ADDR_W-1:0]             rd_addr,
  output logic [DATA_W-1:0]             rd_data,
  output logic                          rd_valid,
  input  logic                          clear_req,
  input  logic [DATA_W-1:0]             clear_value,
  output logic                          busy,
  output logic                          clear_done
);

  localparam int unsigned       BeW    = be_width(DATA_W);
  localparam int unsigned       AddrW1 = ADDR_W + 1;
  localparam logic [ADDR_W:0]   DepthW = AddrW1'(DEPTH);

  if (DATA_W % 8 != 0 || DEPTH == 0 || DEPTH > 2**ADDR_W || $bits(INIT_FILE) == 0)
  begin : g_bad_cfg
    $error("bram_sprite_store: invalid DATA_W/DEPTH/INIT_FILE");
  end

  // Contents are undefined until written or cleared.
  logic [DATA_W-1:0] mem [DEPTH];

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic [DATA_W-1:0] clr_data;

  bram_clear_seq #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_clear_seq (
    .clk           (clk),
    .rst_n         (rst_n),
    .clear_req_i   (clear_req),
    .clear_value_i (clear_value),
    .clr_we_o      (clr_we),
    .clr_addr_o    (clr_addr),
    .clr_data_o    (clr_data),
    .busy_o        (busy),
    .clear_done_o  (clear_done)
  );

  logic wr_in_range, rd_in_range, clear_start, ext_we;

  assign wr_in_range = {1'b0, wr_addr} < DepthW;
  assign rd_in_range = {1'b0, rd_addr} < DepthW;
  // A clear request accepted this cycle takes the write port away from the external writer.
  assign clear_start = clear_req & ~busy;
  assign ext_we      = wr_en & ~busy & ~clear_start & wr_in_range;

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= clr_data;
    end else if (ext_we) begin
      for (int k = 0; k < BeW; k++) begin
        if (wr_be[k]) mem[wr_addr][8*k +: 8] <= wr_data[8*k +: 8];
      end
    end
  end

  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              wr_rejected_q, wr_rejected_d;

  always_comb begin
    rd_data_d     = rd_data_q;
    rd_valid_d    = 1'b0;
    wr_rejected_d = wr_en & (busy | clear_start | ~wr_in_range);
    if (rd_en) begin
      rd_valid_d = 1'b1;
      rd_data_d  = rd_in_range ? mem[rd_addr] : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q     <= '0;
      rd_valid_q    <= 1'b0;
      wr_rejected_q <= 1'b0;
    end else begin
      rd_data_q     <= rd_data_d;
      rd_valid_q    <= rd_valid_d;
      wr_rejected_q <= wr_rejected_d;
    end
  end

  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
  assign wr_rejected = wr_rejected_q;

endmodule

// File: tb/tb_bram_sprite_store.sv
// Drives a full-depth and a partial-depth store with shared stimulus against an array model.
module tb_bram_sprite_store;

  localparam int unsigned DepthFull = 8192;
  localparam int unsigned DepthPart = 6000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [12:0] wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic [1:0]  wr_be = '0;
  logic        rd_en = 1'b0;
  logic [12:0] rd_addr = '0;
  logic        clear_req = 1'b0;
  logic [15:0] clear_value = '0;

  logic [15:0] rd_data_f, rd_data_p;
  logic        rd_valid_f, rd_valid_p, busy_f, busy_p, done_f, done_p, rej_f, rej_p;

  always #5 clk = ~clk;

  bram_sprite_store #(.ADDR_W(13), .DATA_W(16), .DEPTH(DepthFull)) u_full (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .wr_rejected(rej_f), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data_f), .rd_valid(rd_valid_f), .clear_req(clear_req),
    .clear_value(clear_value), .busy(busy_f), .clear_done(done_f)
  );

  bram_sprite_store #(.ADDR_W(13), .DATA_W(16), .DEPTH(DepthPart)) u_part (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .wr_rejected(rej_p), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data_p), .rd_valid(rd_valid_p), .clear_req(clear_req),
    .clear_value(clear_value), .busy(busy_p), .clear_done(done_p)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: index 0 = full-depth instance, 1 = partial-depth instance.
  logic [15:0] m_mem [2][8192];
  int          m_depth [2] = '{DepthFull, DepthPart};
  bit          m_busy [2];
  int          m_left [2];
  int          m_next [2];
  logic [15:0] m_val [2];
  logic [15:0] m_rd [2];
  bit          m_valid [2], m_done [2], m_rej [2];

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_busy[i] = 0; m_left[i] = 0; m_next[i] = 0; m_val[i] = '0;
      m_rd[i] = '0; m_valid[i] = 0; m_done[i] = 0; m_rej[i] = 0;
    end
  endfunction

  function automatic void model_edge(int i);
    m_rej[i]   = wr_en && (m_busy[i] || clear_req || int'(wr_addr) >= m_depth[i]);
    m_valid[i] = rd_en;
    if (rd_en) m_rd[i] = (int'(rd_addr) < m_depth[i]) ? m_mem[i][rd_addr] : 16'h0000;
    m_done[i] = 0;
    if (m_busy[i]) begin
      m_mem[i][m_next[i]] = m_val[i];
      m_next[i]++;
      m_left[i]--;
      if (m_left[i] == 0) begin
        m_busy[i] = 0;
        m_done[i] = 1;
      end
    end else if (clear_req) begin
      m_busy[i] = 1;
      m_left[i] = m_depth[i];
      m_next[i] = 0;
      m_val[i]  = clear_value;
    end else if (wr_en && int'(wr_addr) < m_depth[i]) begin
      for (int b = 0; b < 2; b++)
        if (wr_be[b]) m_mem[i][wr_addr][8*b +: 8] = wr_data[8*b +: 8];
    end
  endfunction

  task automatic compare_all();
    check("rd_data_full", rd_data_f, m_rd[0]);
    check("rd_data_part", rd_data_p, m_rd[1]);
    check("rd_valid_full", rd_valid_f, m_valid[0]);
    check("rd_valid_part", rd_valid_p, m_valid[1]);
    check("busy_full", busy_f, m_busy[0]);
    check("busy_part", busy_p, m_busy[1]);
    check("done_full", done_f, m_done[0]);
    check("done_part", done_p, m_done[1]);
    check("rej_full", rej_f, m_rej[0]);
    check("rej_part", rej_p, m_rej[1]);
  endtask

  task automatic step(input bit we, input logic [12:0] wa, input logic [15:0] wd,
                      input logic [1:0] be, input bit re, input logic [12:0] ra,
                      input bit cr, input logic [15:0] cv);
    wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
    rd_en = re; rd_addr = ra; clear_req = cr; clear_value = cv;
    model_edge(0);
    model_edge(1);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle();
    step(0, '0, '0, '0, 0, '0, 0, '0);
  endtask

  task automatic read(input logic [12:0] a);
    step(0, '0, '0, '0, 1, a, 0, '0);
  endtask

  task automatic run_clear(input logic [15:0] val, input int rej_at);
    int bf = 0, bp = 0, df = 0, dp = 0, n = 0;
    step(0, '0, '0, '0, 0, '0, 1, val);
    bf += int'(busy_f); bp += int'(busy_p);
    while ((busy_f || busy_p) && n < 9000) begin
      if (n == rej_at) begin
        step(1, 13'd10, 16'h5A5A, 2'b11, 0, '0, 0, '0);
        check("rej_in_clear_full", rej_f, 1);
        check("rej_in_clear_part", rej_p, 1);
      end else begin
        idle();
      end
      bf += int'(busy_f); bp += int'(busy_p);
      df += int'(done_f); dp += int'(done_p);
      n++;
    end
    check("busy_cycles_full", bf, DepthFull);
    check("busy_cycles_part", bp, DepthPart);
    check("done_pulses_full", df, 1);
    check("done_pulses_part", dp, 1);
  endtask

  function automatic logic [12:0] pick();
    logic [12:0] a;
    case ($urandom % 4)
      0:       a = 13'($urandom_range(0, 15));
      1:       a = 13'($urandom_range(5990, 6010));
      2:       a = 13'($urandom_range(8180, 8191));
      default: a = 13'($urandom % 8192);
    endcase
    return a;
  endfunction

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_rd_data", {rd_data_f, rd_data_p}, 32'h0);
    check("reset_rd_valid", {rd_valid_f, rd_valid_p}, 0);
    check("reset_busy", {busy_f, busy_p}, 0);
    check("reset_done", {done_f, done_p}, 0);
    check("reset_rej", {rej_f, rej_p}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_clear(16'h0000, -1);

    step(1, 13'd5, 16'hF800, 2'b11, 0, '0, 0, '0);
    read(13'd5);
    check("wr_full_word", rd_data_f, 16'hF800);
    check("wr_full_valid", rd_valid_f, 1);
    idle();
    check("valid_one_cycle", rd_valid_f, 0);
    check("rd_data_holds", rd_data_f, 16'hF800);

    step(1, 13'd5, 16'h1234, 2'b01, 0, '0, 0, '0);
    read(13'd5);
    check("byte_enable_merge", rd_data_f, 16'hF834);

    step(1, 13'd7, 16'hFFFF, 2'b11, 1, 13'd7, 0, '0);
    check("read_first_old", rd_data_f, 16'h0000);
    read(13'd7);
    check("read_first_new", rd_data_f, 16'hFFFF);

    step(1, 13'd9, 16'h3C3C, 2'b00, 0, '0, 0, '0);
    check("be_zero_no_reject", rej_f, 0);

    step(1, 13'd6500, 16'h1111, 2'b11, 0, '0, 0, '0);
    check("oor_write_rej_part", rej_p, 1);
    check("inrange_write_ok_full", rej_f, 0);
    read(13'd6500);
    check("oor_read_zero_part", rd_data_p, 16'h0000);
    check("oor_read_valid_part", rd_valid_p, 1);
    check("read_6500_full", rd_data_f, 16'h1111);

    for (int c = 0; c < 1500; c++) begin
      step(($urandom % 3) == 0, pick(), 16'($urandom), 2'($urandom),
           ($urandom % 2) == 1, pick(), 0, '0);
    end

    run_clear(16'h07E0, 100);
    read(13'd0);
    check("clear_addr0", {rd_data_f, rd_data_p}, {16'h07E0, 16'h07E0});
    read(13'd4000);
    check("clear_addr4000", {rd_data_f, rd_data_p}, {16'h07E0, 16'h07E0});
    read(13'd8191);
    check("clear_addr8191", {rd_data_f, rd_data_p}, {16'h07E0, 16'h0000});
    read(13'd10);
    check("rejected_write_absent", {rd_data_f, rd_data_p}, {16'h07E0, 16'h07E0});

    step(1, 13'd3, 16'h9999, 2'b11, 0, '0, 1, 16'hABCD);
    check("clear_beats_write_rej", rej_f, 1);
    repeat (99) idle();
    rst_n = 1'b0;
    #1;
    check("abort_busy", {busy_f, busy_p}, 0);
    check("abort_done", {done_f, done_p}, 0);
    check("abort_rd_data", {rd_data_f, rd_data_p}, 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) idle();
    read(13'd50);
    check("abort_addr50_cleared", rd_data_f, 16'hABCD);
    read(13'd200);
    check("abort_addr200_kept", rd_data_f, 16'h07E0);
    read(13'd3);
    check("abort_addr3_cleared", rd_data_p, 16'hABCD);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
